// File: rtl/lock_pkg.sv
// lock_pkg
// Shared definitions for the password-lock controller: FSM state encoding,
// command key codes, fixed display words and the seconds-counter width.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_SETPWD  = 3'd3,
        ST_ERROR   = 3'd4,
        ST_LOCKOUT = 3'd5
    } lock_state_t;

    localparam logic [3:0]  KEY_ENTER     = 4'hA;
    localparam logic [3:0]  KEY_CLR       = 4'hB;
    localparam logic [3:0]  KEY_SET       = 4'hC;
    localparam logic [3:0]  KEY_MAX_DIGIT = 4'h9;

    localparam logic [15:0] DISP_OPEN  = 16'hAAAA;
    localparam logic [15:0] DISP_ERR   = 16'hEEEE;
    localparam logic [15:0] DISP_BLANK = 16'hFFFF;

    // Upper byte of the display while counting down a lockout.
    localparam logic [7:0]  DISP_LOCK_HI = 8'hEE;

    // Lockout seconds never exceed 99, so 7 bits are enough.
    localparam int SECS_W = 7;

endpackage

// File: rtl/lock_timer.sv
// lock_timer
// Timebase for the ERROR and LOCKOUT states: a CLK_HZ-cycle prescaler that
// produces a one-cycle tick per second while running, plus a loadable seconds
// down-counter.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   run        prescaler advances while high
//   load       clears the prescaler and loads secs from load_secs
//   load_secs  value loaded into the seconds counter
//   tick       high for the last cycle of every CLK_HZ-cycle period
//   secs       remaining seconds
module lock_timer
    import lock_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              load,
    input  logic [SECS_W-1:0] load_secs,
    output logic              tick,
    output logic [SECS_W-1:0] secs
);

    localparam int               PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] pre_cnt;

    // The tick is taken from the prescaler register, so the consumer sees it
    // in the cycle whose closing edge completes a full CLK_HZ-cycle period.
    assign tick = run && (pre_cnt == PRE_LAST);

    // Prescaler: load restarts the period from zero so a new ERROR or
    // LOCKOUT never inherits phase from an earlier one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (load) begin
            pre_cnt <= '0;
        end else if (run) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end

    // Seconds counter: steps down once per tick and saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            secs <= '0;
        end else if (load) begin
            secs <= load_secs;
        end else if (tick && (secs != '0)) begin
            secs <= secs - 1'b1;
        end
    end

endmodule

// File: rtl/lock_ctrl.sv
// lock_ctrl
// Password-lock controller. Collects 4-digit codes from single-cycle key
// events, checks them against a stored password, handles unlock, password
// change, error display and timed lockout after repeated failures. Drives the
// 4-nibble word for the seven-segment display stage (nibble 0 = rightmost).
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_valid  one-cycle key event strobe
//   key_code   0-9 digit, A enter, B clear/relock, C set password, D-F unused
//   disp_data  four hex nibbles for the display stage
//   unlocked   high in OPEN and SETPWD
//   alarm      high in LOCKOUT
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int          CLK_HZ      = 100_000_000,
    parameter int          LOCK_SEC    = 10,
    parameter int          MAX_TRIES   = 3,
    parameter logic [15:0] DEFAULT_PWD = 16'h1234
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] disp_data,
    output logic        unlocked,
    output logic        alarm
);

    lock_state_t       state;
    logic [15:0]       code_buf;
    logic [15:0]       pwd;
    logic [2:0]        cnt;
    logic [2:0]        tries;
    logic              timer_tick;
    logic [SECS_W-1:0] secs;

    // Binary to two BCD digits; inputs never exceed 99.
    function automatic logic [7:0] to_bcd(input logic [SECS_W-1:0] val);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(val / 7'd10);
        ones = 4'(val % 7'd10);
        return {tens, ones};
    endfunction

    logic        key_digit;
    logic        key_enter;
    logic        key_clr;
    logic        key_set;
    logic        buf_full;
    logic [15:0] buf_shifted;
    logic [2:0]  tries_next;

    assign key_digit   = key_valid && (key_code <= KEY_MAX_DIGIT);
    assign key_enter   = key_valid && (key_code == KEY_ENTER);
    assign key_clr     = key_valid && (key_code == KEY_CLR);
    assign key_set     = key_valid && (key_code == KEY_SET);
    assign buf_full    = (cnt == 3'd4);
    assign buf_shifted = {code_buf[11:0], key_code};
    assign tries_next  = tries + 3'd1;

    // CHECK always precedes ERROR and LOCKOUT, so loading the timer there
    // restarts the prescaler on every entry to either timed state.
    lock_timer #(
        .CLK_HZ (CLK_HZ)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       ((state == ST_ERROR) || (state == ST_LOCKOUT)),
        .load      (state == ST_CHECK),
        .load_secs (SECS_W'(LOCK_SEC)),
        .tick      (timer_tick),
        .secs      (secs)
    );

    // Main FSM with registered outputs: every output is written on the same
    // edge as the state change that implies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ENTRY;
            code_buf  <= DISP_BLANK;
            cnt       <= 3'd0;
            pwd       <= DEFAULT_PWD;
            tries     <= 3'd0;
            disp_data <= DISP_BLANK;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            case (state)
                ST_ENTRY, ST_SETPWD: begin
                    if (key_digit && !buf_full) begin
                        code_buf  <= buf_shifted;
                        cnt       <= cnt + 3'd1;
                        disp_data <= buf_shifted;
                    end else if (key_clr) begin
                        code_buf  <= DISP_BLANK;
                        cnt       <= 3'd0;
                        disp_data <= DISP_BLANK;
                    end else if (key_enter && buf_full) begin
                        if (state == ST_ENTRY) begin
                            state <= ST_CHECK;
                        end else begin
                            pwd       <= code_buf;
                            code_buf  <= DISP_BLANK;
                            cnt       <= 3'd0;
                            state     <= ST_OPEN;
                            disp_data <= DISP_OPEN;
                        end
                    end
                end

                // The display keeps showing the entered code for this one
                // cycle; the verdict appears on the following edge.
                ST_CHECK: begin
                    code_buf <= DISP_BLANK;
                    cnt      <= 3'd0;
                    if (code_buf == pwd) begin
                        tries     <= 3'd0;
                        state     <= ST_OPEN;
                        disp_data <= DISP_OPEN;
                        unlocked  <= 1'b1;
                    end else begin
                        tries <= tries_next;
                        if (tries_next == 3'(MAX_TRIES)) begin
                            state     <= ST_LOCKOUT;
                            disp_data <= {DISP_LOCK_HI, to_bcd(SECS_W'(LOCK_SEC))};
                            alarm     <= 1'b1;
                        end else begin
                            state     <= ST_ERROR;
                            disp_data <= DISP_ERR;
                        end
                    end
                end

                ST_OPEN: begin
                    if (key_set) begin
                        state     <= ST_SETPWD;
                        disp_data <= DISP_BLANK;
                    end else if (key_clr) begin
                        state     <= ST_ENTRY;
                        disp_data <= DISP_BLANK;
                        unlocked  <= 1'b0;
                    end
                end

                ST_ERROR: begin
                    if (timer_tick) begin
                        state     <= ST_ENTRY;
                        disp_data <= DISP_BLANK;
                    end
                end

                // The tick that would take secs to zero leaves instead, so
                // a zero count is never shown.
                ST_LOCKOUT: begin
                    if (timer_tick) begin
                        if (secs <= SECS_W'(1)) begin
                            state     <= ST_ENTRY;
                            tries     <= 3'd0;
                            disp_data <= DISP_BLANK;
                            alarm     <= 1'b0;
                        end else begin
                            disp_data <= {DISP_LOCK_HI, to_bcd(secs - SECS_W'(1))};
                        end
                    end
                end

                default: begin
                    state     <= ST_ENTRY;
                    disp_data <= DISP_BLANK;
                    unlocked  <= 1'b0;
                    alarm     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl
// Self-checking bench for lock_ctrl with CLK_HZ=10, LOCK_SEC=3, MAX_TRIES=3.
// A behavioural model tracks the lock at the level of digit lists, a password
// array and a cycle countdown; one process compares the DUT with it after
// every clock edge, and the directed sequence adds hand-computed checks.
module tb_lock_ctrl;

    localparam int CLK_HZ    = 10;
    localparam int LOCK_SEC  = 3;
    localparam int MAX_TRIES = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [15:0] disp_data;
    logic        unlocked;
    logic        alarm;

    int check_count = 0;
    int fail_count  = 0;

    lock_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .LOCK_SEC    (LOCK_SEC),
        .MAX_TRIES   (MAX_TRIES),
        .DEFAULT_PWD (16'h1234)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .disp_data (disp_data),
        .unlocked  (unlocked),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum {M_ENTRY, M_CHECK, M_OPEN, M_SETPWD, M_ERROR, M_LOCKOUT} mode_t;

    mode_t m_mode;
    int    m_digits[$];
    int    m_pwd[4];
    int    m_tries;
    int    m_remain;

    task automatic model_reset();
        m_mode = M_ENTRY;
        m_digits.delete();
        m_pwd = '{1, 2, 3, 4};
        m_tries = 0;
        m_remain = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kc);
        bit ok;
        case (m_mode)
            M_ENTRY, M_SETPWD: begin
                if (kv && kc <= 4'd9) begin
                    if (m_digits.size() < 4) m_digits.push_back(int'(kc));
                end else if (kv && kc == 4'hB) begin
                    m_digits.delete();
                end else if (kv && kc == 4'hA && m_digits.size() == 4) begin
                    if (m_mode == M_ENTRY) begin
                        m_mode = M_CHECK;
                    end else begin
                        for (int i = 0; i < 4; i++) m_pwd[i] = m_digits[i];
                        m_digits.delete();
                        m_mode = M_OPEN;
                    end
                end
            end
            M_CHECK: begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++) if (m_digits[i] != m_pwd[i]) ok = 1'b0;
                m_digits.delete();
                if (ok) begin
                    m_tries = 0;
                    m_mode = M_OPEN;
                end else begin
                    m_tries++;
                    if (m_tries == MAX_TRIES) begin
                        m_mode = M_LOCKOUT;
                        m_remain = LOCK_SEC * CLK_HZ;
                    end else begin
                        m_mode = M_ERROR;
                        m_remain = CLK_HZ;
                    end
                end
            end
            M_OPEN: begin
                if (kv && kc == 4'hC) m_mode = M_SETPWD;
                else if (kv && kc == 4'hB) m_mode = M_ENTRY;
            end
            M_ERROR: begin
                m_remain--;
                if (m_remain == 0) m_mode = M_ENTRY;
            end
            M_LOCKOUT: begin
                m_remain--;
                if (m_remain == 0) begin
                    m_mode = M_ENTRY;
                    m_tries = 0;
                end
            end
            default: m_mode = M_ENTRY;
        endcase
    endtask

    function automatic logic [15:0] model_disp();
        logic [15:0] r;
        int n;
        int s;
        r = 16'hFFFF;
        case (m_mode)
            M_OPEN:  r = 16'hAAAA;
            M_ERROR: r = 16'hEEEE;
            M_LOCKOUT: begin
                s = (m_remain + CLK_HZ - 1) / CLK_HZ;
                r = {8'hEE, 4'(s / 10), 4'(s % 10)};
            end
            default: begin
                n = m_digits.size();
                for (int i = 0; i < n; i++) r[4*i +: 4] = 4'(m_digits[n-1-i]);
            end
        endcase
        return r;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step(key_valid, key_code);
        end
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [15:0] exp_disp,
                               input logic exp_unl, input logic exp_alarm);
        check_count++;
        if (disp_data !== exp_disp || unlocked !== exp_unl || alarm !== exp_alarm) begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: got disp=%h unlocked=%b alarm=%b, expected disp=%h unlocked=%b alarm=%b",
                     name, $time, disp_data, unlocked, alarm, exp_disp, exp_unl, exp_alarm);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput("model", model_disp(),
                        (m_mode == M_OPEN) || (m_mode == M_SETPWD),
                        m_mode == M_LOCKOUT);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic enterCode(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) applyStimulus(code[4*i +: 4]);
        applyStimulus(4'hA);
    endtask

    initial begin
        #100000;
        fail_count++;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset", 16'hFFFF, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct default code
        applyStimulus(4'd1); checkOutput("digit1", 16'hFFF1, 1'b0, 1'b0);
        applyStimulus(4'd2); checkOutput("digit2", 16'hFF12, 1'b0, 1'b0);
        applyStimulus(4'd3); checkOutput("digit3", 16'hF123, 1'b0, 1'b0);
        applyStimulus(4'd4); checkOutput("digit4", 16'h1234, 1'b0, 1'b0);
        applyStimulus(4'hA); checkOutput("check_cycle", 16'h1234, 1'b0, 1'b0);
        @(negedge clk);      checkOutput("open", 16'hAAAA, 1'b1, 1'b0);

        // Short enter, fifth digit, wrong code
        applyStimulus(4'hB); checkOutput("relock", 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(4'd5);
        applyStimulus(4'd6); checkOutput("partial", 16'hFF56, 1'b0, 1'b0);
        applyStimulus(4'hA); checkOutput("short_enter", 16'hFF56, 1'b0, 1'b0);
        @(negedge clk);      checkOutput("short_enter_hold", 16'hFF56, 1'b0, 1'b0);
        applyStimulus(4'hB);
        applyStimulus(4'd7);
        applyStimulus(4'd8);
        applyStimulus(4'd9);
        applyStimulus(4'd0); checkOutput("full_buf", 16'h7890, 1'b0, 1'b0);
        applyStimulus(4'd1); checkOutput("fifth_digit", 16'h7890, 1'b0, 1'b0);
        applyStimulus(4'hA);
        @(negedge clk);      checkOutput("error_entry", 16'hEEEE, 1'b0, 1'b0);
        for (int i = 1; i < CLK_HZ; i++) begin
            @(negedge clk);  checkOutput("error_hold", 16'hEEEE, 1'b0, 1'b0);
        end
        @(negedge clk);      checkOutput("error_exit", 16'hFFFF, 1'b0, 1'b0);

        // Clear tries with a good code, then three wrong codes
        enterCode(16'h1234);
        @(negedge clk);      checkOutput("open_again", 16'hAAAA, 1'b1, 1'b0);
        applyStimulus(4'hB);
        enterCode(16'h1111);
        @(negedge clk);      checkOutput("wrong1", 16'hEEEE, 1'b0, 1'b0);
        repeat (CLK_HZ) @(negedge clk);
        checkOutput("wrong1_exit", 16'hFFFF, 1'b0, 1'b0);
        enterCode(16'h2222);
        @(negedge clk);      checkOutput("wrong2", 16'hEEEE, 1'b0, 1'b0);
        repeat (CLK_HZ) @(negedge clk);
        enterCode(16'h3333);
        @(negedge clk);      checkOutput("lockout_entry", 16'hEE03, 1'b0, 1'b1);
        for (int k = 1; k < LOCK_SEC * CLK_HZ; k++) begin
            key_code  = 4'(k % 16);
            key_valid = 1'b1;
            @(negedge clk);
            checkOutput("lockout_count", {8'hEE, 4'h0, 4'(3 - k / 10)}, 1'b0, 1'b1);
        end
        key_valid = 1'b0;
        @(negedge clk);      checkOutput("lockout_exit", 16'hFFFF, 1'b0, 1'b0);
        enterCode(16'h1234);
        @(negedge clk);      checkOutput("open_after_lockout", 16'hAAAA, 1'b1, 1'b0);

        // Password change
        applyStimulus(4'hC); checkOutput("setpwd_entry", 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(4'd9);
        applyStimulus(4'd8);
        applyStimulus(4'd7);
        applyStimulus(4'd6); checkOutput("setpwd_digits", 16'h9876, 1'b1, 1'b0);
        applyStimulus(4'hA); checkOutput("setpwd_commit", 16'hAAAA, 1'b1, 1'b0);
        applyStimulus(4'hB); checkOutput("relock2", 16'hFFFF, 1'b0, 1'b0);
        enterCode(16'h1234);
        @(negedge clk);      checkOutput("old_pwd_rejected", 16'hEEEE, 1'b0, 1'b0);
        repeat (CLK_HZ) @(negedge clk);
        enterCode(16'h9876);
        @(negedge clk);      checkOutput("new_pwd", 16'hAAAA, 1'b1, 1'b0);

        // Asynchronous reset in SETPWD restores the default password
        applyStimulus(4'hC);
        applyStimulus(4'd1);
        applyStimulus(4'd1); checkOutput("setpwd_partial", 16'hFF11, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enterCode(16'h1234);
        @(negedge clk);      checkOutput("default_pwd_restored", 16'hAAAA, 1'b1, 1'b0);

        // Ignored keys: D in ENTRY, any key during CHECK
        applyStimulus(4'hB);
        applyStimulus(4'd4);
        applyStimulus(4'd2);
        applyStimulus(4'hD); checkOutput("key_d_ignored", 16'hFF42, 1'b0, 1'b0);
        applyStimulus(4'hB);
        enterCode(16'h1234);
        applyStimulus(4'hB); checkOutput("key_in_check_dropped", 16'hAAAA, 1'b1, 1'b0);
        @(negedge clk);      checkOutput("still_open", 16'hAAAA, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
